input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 138 +++++++++++++
 tb/tb_input_debouncer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Two-flop (configurable) synchronizer followed by a four-state debounce FSM.
// Optional DEBOUNCE_EDGE_COUNT_EN adds a saturating 16-bit edge counter output.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_raw,
    output logic        d,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        busy
`ifdef DEBOUNCE_EDGE_COUNT_EN
    ,
    output logic [15:0] edge_cnt
`endif
);

    localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StStableLo,
        StChkHi,
        StStableHi,
        StChkLo
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       d_q, d_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // Only the first stage ever samples the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStableLo;
            cnt_q   <= 8'd0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStableLo: begin
                if (s) begin
                    state_d = StChkHi;
                    cnt_d   = 8'd1;
                end
            end
            StChkHi: begin
                if (!s) begin
                    state_d = StStableLo;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHi;
                    cnt_d   = 8'd0;
                    d_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStableHi: begin
                if (!s) begin
                    state_d = StChkLo;
                    cnt_d   = 8'd1;
                end
            end
            StChkLo: begin
                if (s) begin
                    state_d = StStableHi;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLo;
                    cnt_d   = 8'd0;
                    d_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        d          = d_q;
        rise_pulse = rise_q;
        fall_pulse = fall_q;
        busy       = (state_q == StChkHi) || (state_q == StChkLo);
    end

`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [15:0] edge_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt_q <= 16'd0;
        end else if ((rise_q || fall_q) && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_q <= edge_cnt_q + 16'd1;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (default parameters): per-edge vector table
// plus hand-written reset-mid-check and optional edge-counter sequences.
module tb_input_debouncer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic d_raw = 1'b0;
    logic d, rise_pulse, fall_pulse, busy;
`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [15:0] edge_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_raw     (d_raw),
        .d         (d),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
`ifdef DEBOUNCE_EDGE_COUNT_EN
        ,
        .edge_cnt  (edge_cnt)
`endif
    );

    // exp = {d, rise_pulse, fall_pulse, busy} observed just after the edge
    typedef struct packed {
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic raw, input logic [3:0] exp);
        vec_t v;
        v.raw = raw;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {d, rise_pulse, fall_pulse, busy};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {d,rise,fall,busy}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic raw);
        d_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic add_fall();
        add(1'b0, 4'b1000); add(1'b0, 4'b1000); add(1'b0, 4'b1001);
        add(1'b0, 4'b1001); add(1'b0, 4'b1001); add(1'b0, 4'b0010);
        add(1'b0, 4'b0000);
    endtask

    initial begin
        // clean rise
        add(1'b1, 4'b0000); add(1'b1, 4'b0000); add(1'b1, 4'b0001);
        add(1'b1, 4'b0001); add(1'b1, 4'b0001); add(1'b1, 4'b1100);
        add(1'b1, 4'b1000);
        add_fall();
        // 3-cycle glitch: reversal arrives exactly when cnt would be terminal
        add(1'b1, 4'b0000); add(1'b1, 4'b0000); add(1'b1, 4'b0001);
        add(1'b0, 4'b0001); add(1'b0, 4'b0001); add(1'b0, 4'b0000);
        add(1'b0, 4'b0000); add(1'b0, 4'b0000);
        // bounce 1,0,1,0,1 then held high
        add(1'b1, 4'b0000); add(1'b0, 4'b0000); add(1'b1, 4'b0001);
        add(1'b0, 4'b0000); add(1'b1, 4'b0001); add(1'b1, 4'b0000);
        add(1'b1, 4'b0001); add(1'b1, 4'b0001); add(1'b1, 4'b0001);
        add(1'b1, 4'b1100); add(1'b1, 4'b1000);
        add_fall();

        // reset state, including d_raw=1 during reset
        d_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", 4'b0000);
`ifdef DEBOUNCE_EDGE_COUNT_EN
        n_cmp++;
        if (edge_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL edge_cnt_reset: got %h expected 0000", edge_cnt);
        end
`endif
        d_raw = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_out("post_release", 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].raw);
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset asserted at edge 4 of a rise check
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check_out("midchk_busy", 4'b0001);
        reset = 1'b1;
        #1;
        check_out("midchk_async_reset", 4'b0000);
        @(posedge clk);
        #1;
        check_out("midchk_held", 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1'b1);
            check_out($sformatf("after_reset_e%0d", k),
                      (k == 6) ? 4'b1100 : (k == 7) ? 4'b1000 :
                      (k >= 3) ? 4'b0001 : 4'b0000);
        end

`ifdef DEBOUNCE_EDGE_COUNT_EN
        reset = 1'b1;
        d_raw = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            repeat (8) step(1'b1);
            repeat (8) step(1'b0);
        end
        n_cmp++;
        if (edge_cnt !== 16'd6) begin
            n_err++;
            $display("FAIL edge_cnt_six: got %0d expected 6", edge_cnt);
        end
        force dut.edge_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.edge_cnt_q;
        repeat (8) step(1'b1);
        repeat (8) step(1'b0);
        repeat (8) step(1'b1);
        n_cmp++;
        if (edge_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL edge_cnt_sat: got %h expected ffff", edge_cnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
